muldiv_seq: RTL and testbench

Multi-cycle sequencer for the EX stage's MIPS multiply/divide instructions (mult, multu, div, divu). It accepts one operation from EX, iterates a shift-add (multiply) or restoring shift-subtract (divide) over WIDTH cycles, and writes the HI/LO registers. While it is busy it holds the pipeline stall request so that hazard logic can hold mfhi/mflo and any further mult/div. The single-cycle ALU path is not affected.

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_seq.sv | 133 +++++++++++++
 tb/tb_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes, FSM states and operation kinds for the mult/div sequencer.
package muldiv_pkg;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic {MUL, DIV} op_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request and HI/LO result bundle of the mult/div sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, funct, rs_val, rt_val, flush, input busy, done, hi, lo);
  modport slave (input start, funct, rs_val, rt_val, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration.
// The divide iteration exists only when MULDIV_DIV_EN is defined.
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  op_t              op_i,
`endif
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] aux_i,
  input  logic [WIDTH-1:0] opd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] aux_o
);
  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] trial;
`endif
  always_comb begin
    sum = {1'b0, acc_i} + (aux_i[0] ? {1'b0, opd_i} : '0);
`ifdef MULDIV_DIV_EN
    trial = {acc_i, aux_i[WIDTH-1]} - {1'b0, opd_i};
    acc_o = (op_i == DIV) ? (trial[WIDTH] ? {acc_i[WIDTH-2:0], aux_i[WIDTH-1]} : trial[WIDTH-1:0]) : sum[WIDTH:1];
    aux_o = (op_i == DIV) ? {aux_i[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], aux_i[WIDTH-1:1]};
`else
    acc_o = sum[WIDTH:1];
    aux_o = {sum[0], aux_i[WIDTH-1:1]};
`endif
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle mult/multu/div/divu sequencer driving HI/LO and the stall.
// Define MULDIV_DIV_EN to build div/divu; otherwise those requests are ignored.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave mif
);
  localparam int CW = $clog2(WIDTH);
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, aux_q, aux_d, opd_q, opd_d;
  logic [WIDTH-1:0]   hi_q, lo_q, step_acc, step_aux, abs_a, abs_b;
  logic               neg_q, neg_d, wr_q, wr_d, done_q;
  logic               sgn, sa, sb, is_mul, is_div;
  logic [2*WIDTH-1:0] prod, res;
`ifdef MULDIV_DIV_EN
  op_t                op_q, op_d;
  logic               rneg_q, rneg_d;
  assign is_div = mif.funct == FUNCT_DIV || mif.funct == FUNCT_DIVU;
`else
  assign is_div = 1'b0;
`endif
  assign is_mul = mif.funct == FUNCT_MULT || mif.funct == FUNCT_MULTU;
  assign sgn    = mif.funct == FUNCT_MULT || mif.funct == FUNCT_DIV;
  assign sa     = sgn & mif.rs_val[WIDTH-1];
  assign sb     = sgn & mif.rt_val[WIDTH-1];
  assign abs_a  = sa ? -mif.rs_val : mif.rs_val;
  assign abs_b  = sb ? -mif.rt_val : mif.rt_val;
  assign prod   = {acc_q, aux_q};
  // Iterations run on magnitudes; signs are reapplied once in FIX.
`ifdef MULDIV_DIV_EN
  assign res = (op_q == DIV) ? {rneg_q ? -acc_q : acc_q, neg_q ? -aux_q : aux_q} : neg_q ? -prod : prod;
`else
  assign res = neg_q ? -prod : prod;
`endif
  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .op_i  (op_q),
`endif
    .acc_i (acc_q),
    .aux_i (aux_q),
    .opd_i (opd_q),
    .acc_o (step_acc),
    .aux_o (step_aux)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    aux_d   = aux_q;
    opd_d   = opd_q;
    neg_d   = neg_q;
    wr_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    op_d    = op_q;
    rneg_d  = rneg_q;
`endif
    if (state_q == IDLE) begin
      if (mif.start && !mif.flush && (is_mul || is_div)) begin
        state_d = CALC;
        cnt_d   = CW'(WIDTH - 1);
        acc_d   = '0;
        aux_d   = is_mul ? abs_b : abs_a;
        opd_d   = is_mul ? abs_a : abs_b;
        neg_d   = sa ^ sb;
`ifdef MULDIV_DIV_EN
        op_d    = is_mul ? MUL : DIV;
        rneg_d  = sa;
        if (is_div && mif.rt_val == '0) begin
          state_d = FIX;
          acc_d   = mif.rs_val;
          aux_d   = '1;
          neg_d   = 1'b0;
          rneg_d  = 1'b0;
        end
`endif
      end
    end else if (mif.flush) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      state_d = (cnt_q == '0) ? FIX : CALC;
      cnt_d   = cnt_q - CW'(1);
      acc_d   = step_acc;
      aux_d   = step_aux;
    end else begin
      // Corrected result parks in acc/aux and is published to HI/LO one edge later.
      state_d        = IDLE;
      {acc_d, aux_d} = res;
      wr_d           = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      aux_q   <= '0;
      opd_q   <= '0;
      neg_q   <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      op_q    <= MUL;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      aux_q   <= aux_d;
      opd_q   <= opd_d;
      neg_q   <= neg_d;
      wr_q    <= wr_d;
      done_q  <= wr_q;
      if (wr_q) begin
        hi_q <= acc_q;
        lo_q <= aux_q;
      end
`ifdef MULDIV_DIV_EN
      op_q    <= op_d;
      rneg_q  <= rneg_d;
`endif
    end
  end
  assign mif.busy = state_q != IDLE;
  assign mif.done = done_q;
  assign mif.hi   = hi_q;
  assign mif.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against a timeline reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [5:0] FS [6] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h3F};
  typedef struct {int due; logic [63:0] r;} pend_t;
  logic clk;
  logic rst_n;
  bit go;
  int total;
  int bad;
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .mif(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit legal(logic [5:0] f);
    return f == 6'h18 || f == 6'h19 || (DIV_EN && (f == 6'h1A || f == 6'h1B));
  endfunction
  // {hi, lo} as the architecture defines them, computed with wide host arithmetic.
  function automatic logic [63:0] ref_res(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (f == 6'h19) return {32'b0, a} * {32'b0, b};
    if (f == 6'h18) return 64'(sa * sb);
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (f == 6'h1B) return {a % b, a / b};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction
  pend_t q[$];
  pend_t p;
  bit infl;
  int e;
  int fin;
  logic [63:0] cur;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit m_done;
  bit m_busy;
  // Timeline model: accept at edge e, busy until e+lat-1, result visible after e+lat.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      infl = 0;
      e = 0;
      m_hi = '0;
      m_lo = '0;
      m_done = 0;
      m_busy = 0;
    end else begin
      e++;
      m_done = 0;
      if (q.size() > 0 && q[0].due == e) begin
        {m_hi, m_lo} = q[0].r;
        m_done = 1;
        void'(q.pop_front());
      end
      if (infl) begin
        if (bus.flush) infl = 0;
        else if (e == fin) begin
          infl = 0;
          p.due = e + 1;
          p.r = cur;
          q.push_back(p);
        end
      end else if (bus.start && !bus.flush && legal(bus.funct)) begin
        infl = 1;
        fin = e + ((bus.funct[1] && bus.rt_val == 0) ? 2 : 34) - 1;
        cur = ref_res(bus.funct, bus.rs_val, bus.rt_val);
      end
      m_busy = infl;
    end
  end
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      chk("cyc_busy", bus.busy, m_busy);
      chk("cyc_done", bus.done, m_done);
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end
  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction
  // Called at a negedge: issues the op, waits for done, checks latency, busy length and result.
  task automatic run_op(string nm, logic [5:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] eh, logic [31:0] el, int elat, int noise);
    int k;
    int nb;
    bus.start = 1'b1;
    bus.funct = f;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    nb = 0;
    while (!bus.done && k < 60) begin
      if (bus.busy) nb++;
      bus.start = (k == noise);
      if (k == noise) begin
        bus.funct = FUNCT_MULTU;
        bus.rs_val = 32'd2;
        bus.rt_val = 32'd2;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk({nm, "_lat"}, k, elat);
    chk({nm, "_busy_cycles"}, nb, elat - 1);
    chk({nm, "_hi"}, bus.hi, eh);
    chk({nm, "_lo"}, bus.lo, el);
  endtask
  initial begin
    int nd;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct = 6'h0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("ref_mult", ref_res(FUNCT_MULT, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    chk("ref_divu", ref_res(FUNCT_DIVU, 32'd100, 32'd7), {32'd2, 32'd14});
    chk("ref_div", ref_res(FUNCT_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("ref_ovf", ref_res(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});
    run_op("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 34, -1);
    run_op("mult_neg", FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, -1);
    run_op("start_busy", FUNCT_MULT, 32'd7, 32'd9, 32'h0, 32'd63, 34, 5);
    run_op("back2back", FUNCT_MULTU, 32'h10000, 32'h10000, 32'h1, 32'h0, 34, -1);
    run_op("mult_minmin", FUNCT_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 34, -1);
    bus.start = 1'b1;
    bus.funct = FUNCT_MULTU;
    bus.rs_val = 32'h1234;
    bus.rt_val = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    chk("flush_no_done", nd, 0);
    chk("flush_hi", bus.hi, 32'h40000000);
    chk("flush_lo", bus.lo, 32'h0);
`ifdef MULDIV_DIV_EN
    run_op("div_neg", FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, -1);
    run_op("divu", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, -1);
    run_op("div_ovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, -1);
    run_op("div_zero", FUNCT_DIV, 32'd123, 32'd0, 32'd123, 32'hFFFFFFFF, 2, -1);
    @(negedge clk);
`else
    bus.start = 1'b1;
    bus.funct = FUNCT_DIV;
    bus.rs_val = 32'd10;
    bus.rt_val = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("nodiv_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("nodiv_hi", bus.hi, 32'h40000000);
    chk("nodiv_lo", bus.lo, 32'h0);
`endif
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.funct = FUNCT_MULTU;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.funct = 6'h10;
    @(negedge clk);
    bus.start = 1'b0;
    chk("illegal_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.funct = FUNCT_MULTU;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) begin
      @(negedge clk);
      bus.start = ($urandom_range(7) == 0);
      bus.flush = ($urandom_range(49) == 0);
      bus.funct = FS[$urandom_range(5)];
      bus.rs_val = pick();
      bus.rt_val = pick();
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
